// File: rtl/demux_1x2_8bits_mem.sv
// 1-to-2 byte demultiplexer: alternates accepted bytes between two
// first-word-fall-through lane FIFOs, stalling on a full target lane.
module demux_1x2_8bits_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic                  valid_out0,
  input  logic                  pop0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic                  valid_out1,
  input  logic                  pop1,
  output logic                  full0,
  output logic                  full1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                  sel;
  logic [PW-1:0]         wr_ptr [2];
  logic [PW-1:0]         rd_ptr [2];
  logic [CW-1:0]         count  [2];
  logic [DATA_WIDTH-1:0] mem    [2][DEPTH];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop_fire;
  logic       accept;

  // ready_out depends only on registered state, so pops free space one cycle later
  always_comb begin
    full     = '0;
    empty    = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]  = (count[i] == CW'(DEPTH));
      empty[i] = (count[i] == '0);
    end
    ready_out = ~full[sel];
    accept    = valid_in & ready_out;
    push[0]   = accept & ~sel;
    push[1]   = accept & sel;
    pop_fire  = {pop1, pop0} & ~empty;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (accept)
        sel <= ~sel;
      for (int i = 0; i < 2; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop_fire[i])
          rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop_fire[i])
          count[i] <= count[i] + CW'(1);
        else if (!push[i] && pop_fire[i])
          count[i] <= count[i] - CW'(1);
      end
    end
  end

  // Storage is never cleared; emptiness is tracked by the counters alone
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= data_in;
    end
  end

  assign valid_out0 = ~empty[0];
  assign valid_out1 = ~empty[1];
  assign data_out0  = empty[0] ? '0 : mem[0][rd_ptr[0]];
  assign data_out1  = empty[1] ? '0 : mem[1][rd_ptr[1]];
  assign full0      = full[0];
  assign full1      = full[1];

endmodule
